dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: single-port data memory responder with a fixed-latency busy/done handshake.
// Latency: LATENCY cycles of busy per access, then a one-cycle done pulse carrying data_out/err.
// Backpressure: busy stalls the pipeline combinationally; requests are not accepted in WAIT or DONE.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag (and suppress) accesses with address[1:0] != 0.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

  logic        req;
  logic        accept;
  logic        enter_done;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic        eff_write;
  logic        misalign;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic        unused_bits;

  assign req    = mem_read | mem_write;
  assign accept = (state == IDLE) && req;

  // With LATENCY=1 the access completes on the acceptance edge, so the live
  // inputs are used there; otherwise the values latched at acceptance.
  assign eff_addr  = (state == IDLE) ? address   : addr_q;
  assign eff_wdata = (state == IDLE) ? data_in   : wdata_q;
  assign eff_write = (state == IDLE) ? mem_write : write_q;
  assign word_idx  = eff_addr[DEPTH_LOG2+1:2];

  // Upper address bits alias; low bits only matter for the misalignment check.
  assign unused_bits = ^{eff_addr[31:DEPTH_LOG2+2], eff_addr[1:0]};

  assign enter_done = (state != DONE) && (state_nxt == DONE);
  assign done       = (state == DONE);

  // Next-state, counter and stall decode.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            count_nxt = CNT_INIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (count == 4'd0) state_nxt = DONE;
        else               count_nxt = count - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Capture the request on acceptance; read+write together is treated as a store.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      wdata_q <= data_in;
      write_q <= mem_write;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic err_q;
  assign misalign = (eff_addr[1:0] != 2'b00);
  assign err      = err_q;

  // Error flag is only ever set for the DONE cycle of a misaligned access.
  always_ff @(posedge clk) begin
    if (reset)           err_q <= 1'b0;
    else if (enter_done) err_q <= misalign;
    else                 err_q <= 1'b0;
  end
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  // Array write on the edge entering DONE; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && eff_write && !misalign)
      mem[word_idx] <= eff_wdata;
  end

  // Load data registered on the edge entering DONE; held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 32'd0;
    end else if (enter_done) begin
      if (misalign)        data_out <= 32'd0;
      else if (!eff_write) data_out <= mem[word_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2 (main), 1 and 16.
// Each access is driven at posedge+1 and sampled 1ns later.
// Requests are dropped on the done cycle, as a stalled pipeline would.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, data_in;
  logic        rd0, wr0, rd1, wr1, rd16, wr16;
  logic [31:0] q0, q1, q16;
  logic        b0, b1, b16, d0, d1, d16, e0, e1, e16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0),
    .address(address), .data_in(data_in),
    .data_out(q0), .busy(b0), .done(d0), .err(e0));

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
    .address(address), .data_in(data_in),
    .data_out(q1), .busy(b1), .done(d1), .err(e1));

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(16)) dut16 (
    .clk(clk), .reset(reset), .mem_read(rd16), .mem_write(wr16),
    .address(address), .data_in(data_in),
    .data_out(q16), .busy(b16), .done(d16), .err(e16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return d0;
      1:       return d1;
      default: return d16;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return b0;
      1:       return b1;
      default: return b16;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      0:       return e0;
      1:       return e1;
      default: return e16;
    endcase
  endfunction

  function automatic logic [31:0] get_q(input int sel);
    case (sel)
      0:       return q0;
      1:       return q1;
      default: return q16;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic rd, input logic wr);
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; rd16 = 1'b0; wr16 = 1'b0;
    case (sel)
      0:       begin rd0  = rd; wr0  = wr; end
      1:       begin rd1  = rd; wr1  = wr; end
      default: begin rd16 = rd; wr16 = wr; end
    endcase
  endtask

  // One complete access: busy cycles before done, cycle index of done,
  // data_out/err seen with done, and done one cycle later.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nbusy, output int done_idx,
                        output logic [31:0] q, output logic e, output logic done_after);
    address = a;
    data_in = d;
    set_req(sel, rd, wr);
    nbusy = 0; done_idx = -1; q = 32'd0; e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (get_done(sel)) begin
        done_idx = i;
        q = get_q(sel);
        e = get_err(sel);
        break;
      end
      if (get_busy(sel)) nbusy++;
      @(posedge clk);
    end
    set_req(sel, 1'b0, 1'b0);
    @(posedge clk); #1;
    done_after = get_done(sel);
  endtask

  int          nb, di;
  logic [31:0] q;
  logic        e, da;

  initial begin
    reset = 1'b1;
    address = 32'd0;
    data_in = 32'd0;
    set_req(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", q0, 32'd0);
    check("reset_done", {31'd0, d0}, 32'd0);
    check("reset_err", {31'd0, e0}, 32'd0);
    check("reset_busy", {31'd0, b0}, 32'd0);
    check("reset_data_out_l16", q16, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load, LATENCY=2
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, nb, di, q, e, da);
    check("st10_busy_cycles", nb, 32'd2);
    check("st10_done_cycle", di, 32'd2);
    check("st10_err", {31'd0, e}, 32'd0);
    check("st10_done_width", {31'd0, da}, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, di, q, e, da);
    check("ld10_data", q, 32'hDEADBEEF);
    check("ld10_busy_cycles", nb, 32'd2);
    @(posedge clk); #1;
    check("idle_hold_data_out", q0, 32'hDEADBEEF);

    // Aliasing: 0x404 maps to the same word as 0x004
    access(0, 1'b0, 1'b1, 32'h004, 32'h12345678, nb, di, q, e, da);
    access(0, 1'b1, 1'b0, 32'h404, 32'h0, nb, di, q, e, da);
    check("alias_ld404", q, 32'h12345678);

    // Reset during WAIT of a store abandons it
    access(0, 1'b0, 1'b1, 32'h20, 32'h11111111, nb, di, q, e, da);
    address = 32'h20; data_in = 32'hAAAA5555; wr0 = 1'b1;
    #1;
    check("rst_mid_busy_idle", {31'd0, b0}, 32'd1);
    @(posedge clk); #1;
    check("rst_mid_busy_wait", {31'd0, b0}, 32'd1);
    reset = 1'b1; wr0 = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_done", {31'd0, d0}, 32'd0);
    check("rst_mid_data_out", q0, 32'd0);
    check("rst_mid_busy_after", {31'd0, b0}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, nb, di, q, e, da);
    check("rst_mid_ld20_prior", q, 32'h11111111);

    // Read+write together is a store; data_out unchanged
    access(0, 1'b1, 1'b1, 32'h08, 32'h0F0F0F0F, nb, di, q, e, da);
    check("rw_data_out_held", q, 32'h11111111);
    check("rw_busy_cycles", nb, 32'd2);
    access(0, 1'b1, 1'b0, 32'h08, 32'h0, nb, di, q, e, da);
    check("rw_ld08", q, 32'h0F0F0F0F);

    // Back-to-back: request held through DONE is only taken in the next IDLE
    address = 32'h10; rd0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_first_done", {31'd0, d0}, 32'd1);
    check("b2b_first_data", q0, 32'hDEADBEEF);
    address = 32'h08;
    #1;
    check("b2b_busy_in_done", {31'd0, b0}, 32'd0);
    @(posedge clk); #1;
    check("b2b_idle_done", {31'd0, d0}, 32'd0);
    check("b2b_idle_busy", {31'd0, b0}, 32'd1);
    @(posedge clk); #1;
    check("b2b_wait_done", {31'd0, d0}, 32'd0);
    @(posedge clk); #1;
    check("b2b_second_done", {31'd0, d0}, 32'd1);
    check("b2b_second_data", q0, 32'h0F0F0F0F);
    rd0 = 1'b0;
    @(posedge clk); #1;

    // Misaligned store to 0x11
    access(0, 1'b0, 1'b1, 32'h11, 32'h55AA55AA, nb, di, q, e, da);
    check("mis_busy_cycles", nb, 32'd2);
    check("mis_err_after", {31'd0, e0}, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_err", {31'd0, e}, 32'd1);
    check("mis_data_out", q, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, di, q, e, da);
    check("mis_word10_kept", q, 32'hDEADBEEF);
`else
    check("mis_err", {31'd0, e}, 32'd0);
    check("mis_data_out", q, 32'h0F0F0F0F);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, di, q, e, da);
    check("mis_word10_written", q, 32'h55AA55AA);
`endif
    check("ld_after_mis_err", {31'd0, e}, 32'd0);

    // LATENCY=1
    access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, nb, di, q, e, da);
    check("l1_busy_cycles", nb, 32'd1);
    check("l1_done_cycle", di, 32'd1);
    check("l1_done_width", {31'd0, da}, 32'd0);
    access(1, 1'b1, 1'b0, 32'h40, 32'h0, nb, di, q, e, da);
    check("l1_ld40", q, 32'hCAFEF00D);

    // LATENCY=16
    access(2, 1'b0, 1'b1, 32'h44, 32'h0BADC0DE, nb, di, q, e, da);
    check("l16_busy_cycles", nb, 32'd16);
    check("l16_done_cycle", di, 32'd16);
    check("l16_done_width", {31'd0, da}, 32'd0);
    access(2, 1'b1, 1'b0, 32'h44, 32'h0, nb, di, q, e, da);
    check("l16_ld44", q, 32'h0BADC0DE);
    check("l16_ld_busy_cycles", nb, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
